// File: rtl/approx_div_seq.sv
// Sequential restoring divider that reconstructs X ~= floor((P << N) / Y) from the
// approximate multiplier's high product nibble, with saturation and divide-by-zero flags.
module approx_div_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] p_in,
  input  logic [N-1:0] y_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] x_out,
  output logic [N-1:0] rem_out,
  output logic         sat,
  output logic         dz
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  div_q, div_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  rout_q, rout_d;
  logic          sat_q, sat_d;
  logic          dz_q, dz_d;
  logic          ov_q, ov_d;

  logic signed [N+1:0] trial;
  logic [N-1:0]        rem_step;
  logic [N-1:0]        q_step;

  // One restoring step: shift the partial remainder left and try to subtract the divisor.
  always_comb begin
    trial = $signed({1'b0, rem_q, 1'b0}) - $signed({2'b00, div_q});
    if (!trial[N+1]) begin
      rem_step = N'(trial);
      q_step   = (q_q << 1) | N'(1);
    end else begin
      rem_step = N'({rem_q, 1'b0});
      q_step   = q_q << 1;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    rout_d  = rout_q;
    sat_d   = sat_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (y_in == '0) begin
            x_d     = '1;
            rout_d  = '0;
            dz_d    = 1'b1;
            sat_d   = 1'b0;
            ov_d    = 1'b1;
            state_d = DONE;
          end else if (p_in >= y_in) begin
            // Quotient would need more than N bits.
            x_d     = '1;
            rout_d  = '0;
            sat_d   = 1'b1;
            dz_d    = 1'b0;
            ov_d    = 1'b1;
            state_d = DONE;
          end else begin
            div_d   = y_in;
            rem_d   = p_in;
            q_d     = '0;
            cnt_d   = CW'(N);
            sat_d   = 1'b0;
            dz_d    = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_step;
        q_d   = q_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          x_d     = q_step;
          rout_d  = rem_step;
          ov_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      rout_q  <= '0;
      sat_q   <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      rout_q  <= rout_d;
      sat_q   <= sat_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign x_out     = x_q;
  assign rem_out   = rout_q;
  assign sat       = sat_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_approx_div_seq.sv
// Bench for approx_div_seq: directed vector table, backpressure and mid-operation
// reset sequences, and a randomized sweep of all (P, Y) pairs against a reference model.
module tb_approx_div_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] p_in;
  logic [3:0] y_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] x_out;
  logic [3:0] rem_out;
  logic       sat;
  logic       dz;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  approx_div_seq #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .p_in(p_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .rem_out(rem_out), .sat(sat), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int p; int y; int x; int r; int s; int d; int lat;
  } vec_t;

  typedef struct {
    int p; int y; int x; int r; int s; int d; int lat; int acc;
  } exp_t;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: quotient and remainder of the N-bit-shifted dividend, plain integer math.
  function automatic exp_t ref_model(input int p, input int y);
    exp_t e;
    e.p = p; e.y = y; e.acc = 0;
    if (y == 0) begin
      e.x = 15; e.r = 0; e.s = 0; e.d = 1; e.lat = 0;
    end else if (p * 16 / y > 15) begin
      e.x = 15; e.r = 0; e.s = 1; e.d = 0; e.lat = 0;
    end else begin
      e.x = p * 16 / y; e.r = p * 16 % y; e.s = 0; e.d = 0; e.lat = 4;
    end
    return e;
  endfunction

  task automatic do_op(input vec_t v);
    int guard;
    int lat;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_op", int'(in_ready), 1);
    p_in = 4'(v.p); y_in = 4'(v.y); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    p_in = 4'($urandom); y_in = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("lat p=%0d y=%0d", v.p, v.y), lat, v.lat);
    chk($sformatf("x p=%0d y=%0d", v.p, v.y), int'(x_out), v.x);
    chk($sformatf("rem p=%0d y=%0d", v.p, v.y), int'(rem_out), v.r);
    chk($sformatf("sat p=%0d y=%0d", v.p, v.y), int'(sat), v.s);
    chk($sformatf("dz p=%0d y=%0d", v.p, v.y), int'(dz), v.d);
    @(posedge clk); #1;
    chk("out_valid_after_hs", int'(out_valid), 0);
    chk("in_ready_after_hs", int'(in_ready), 1);
  endtask

  vec_t vecs[10];
  exp_t expq[$];
  int   order[256];
  bit   drv_done;

  initial begin
    int   guard;
    int   ov_seen;
    vec_t v;

    vecs[0] = '{p: 6,  y: 9,  x: 10, r: 6,  s: 0, d: 0, lat: 4};
    vecs[1] = '{p: 9,  y: 9,  x: 15, r: 0,  s: 1, d: 0, lat: 0};
    vecs[2] = '{p: 14, y: 15, x: 14, r: 14, s: 0, d: 0, lat: 4};
    vecs[3] = '{p: 5,  y: 0,  x: 15, r: 0,  s: 0, d: 1, lat: 0};
    vecs[4] = '{p: 0,  y: 5,  x: 0,  r: 0,  s: 0, d: 0, lat: 4};
    vecs[5] = '{p: 1,  y: 3,  x: 5,  r: 1,  s: 0, d: 0, lat: 4};
    vecs[6] = '{p: 15, y: 0,  x: 15, r: 0,  s: 0, d: 1, lat: 0};
    vecs[7] = '{p: 15, y: 15, x: 15, r: 0,  s: 1, d: 0, lat: 0};
    vecs[8] = '{p: 7,  y: 8,  x: 14, r: 0,  s: 0, d: 0, lat: 4};
    vecs[9] = '{p: 0,  y: 1,  x: 0,  r: 0,  s: 0, d: 0, lat: 4};

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; p_in = '0; y_in = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst x_out", int'(x_out), 0);
    chk("rst rem_out", int'(rem_out), 0);
    chk("rst sat", int'(sat), 0);
    chk("rst dz", int'(dz), 0);
    chk("rst in_ready", int'(in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_op(vecs[i]);

    // Backpressure: result must hold and new operands must be refused.
    out_ready = 1'b0;
    @(negedge clk);
    p_in = 4'd3; y_in = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("bp latency", guard, 4);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b1; p_in = 4'($urandom); y_in = 4'($urandom);
      @(posedge clk); #1;
      chk("bp out_valid", int'(out_valid), 1);
      chk("bp x_out", int'(x_out), 6);
      chk("bp rem_out", int'(rem_out), 6);
      chk("bp in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", int'(out_valid), 0);
    chk("bp release in_ready", int'(in_ready), 1);

    // Reset two steps into CALC must drop the operation entirely.
    @(negedge clk);
    p_in = 4'd2; y_in = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst in_ready", int'(in_ready), 1);
    chk("midrst x_out", int'(x_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    chk("midrst no output", ov_seen, 0);
    do_op(vecs[5]);

    // Randomized sweep over every (P, Y) pair in shuffled order with random gaps.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(i, 0);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    drv_done = 1'b0;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          int gap;
          int g;
          exp_t e;
          gap = $urandom_range(2, 0);
          for (int k = 0; k < gap; k++) begin
            in_valid = 1'b0;
            p_in = 4'($urandom); y_in = 4'($urandom);
            @(negedge clk);
          end
          p_in = 4'(order[i] / 16); y_in = 4'(order[i] % 16); in_valid = 1'b1;
          g = 0;
          while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
          end
          if (g >= 200) chk("sweep accept timeout", g, 0);
          e = ref_model(order[i] / 16, order[i] % 16);
          e.acc = cyc + 1;
          expq.push_back(e);
          @(negedge clk);
        end
        in_valid = 1'b0;
        drv_done = 1'b1;
      end
      begin
        bit   seen;
        int   g;
        exp_t e;
        logic [9:0] held;
        seen = 1'b0;
        g = 0;
        while ((!drv_done || expq.size() > 0 || seen) && g < 20000) begin
          @(negedge clk);
          g++;
          if (out_valid) begin
            if (!seen) begin
              if (expq.size() == 0) begin
                chk("sweep unexpected result", 1, 0);
              end else begin
                e = expq.pop_front();
                chk($sformatf("sweep lat p=%0d y=%0d", e.p, e.y), cyc - e.acc, e.lat);
                chk($sformatf("sweep x p=%0d y=%0d", e.p, e.y), int'(x_out), e.x);
                chk($sformatf("sweep rem p=%0d y=%0d", e.p, e.y), int'(rem_out), e.r);
                chk($sformatf("sweep sat p=%0d y=%0d", e.p, e.y), int'(sat), e.s);
                chk($sformatf("sweep dz p=%0d y=%0d", e.p, e.y), int'(dz), e.d);
              end
              held = {x_out, rem_out, sat, dz};
              seen = 1'b1;
            end else begin
              chk("sweep held outputs", int'({x_out, rem_out, sat, dz}), int'(held));
            end
          end
          out_ready = ($urandom_range(3, 0) != 0);
          if (out_valid && out_ready) seen = 1'b0;
        end
        if (g >= 20000) chk("sweep drain timeout", g, 0);
      end
    join
    chk("sweep leftover results", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
